i2c_mon_tx_scheduler: RTL and testbench
=======================================

// Module: i2c_mon_tx_scheduler
// PURPOSE
//  Sits between i2c_monitor's decoded event-byte stream ('S', addr, 'A', data, 'N', 0x80 stop ...)
//  and the UART transmitter. Buffers bursty, non-stallable monitor bytes in a FIFO and schedules
//  them onto a valid/ready TX port. Records bytes lost to overflow and reports them in-band.
//  Optionally arbitrates a low-priority heartbeat byte onto the same TX port.
// PARAMETERS
//  DEPTH      16        FIFO entries; power of 2, >= 4
//  OVF_MARK   8'h4F     marker byte ('O') emitted ahead of a drop report
//  HB_BYTE    8'h48     heartbeat byte ('H'); HEARTBEAT_EN only
//  HB_PERIOD  50000000  heartbeat interval in clk cycles; HEARTBEAT_EN only
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  rst        in   1  asynchronous, active-low reset (0 = reset)
//  ev_valid   in   1  monitor byte strobe, 1-cycle pulse; no backpressure
//  ev_data    in   8  monitor byte, sampled when ev_valid=1
//  tx_valid   out  1  output byte available
//  tx_data    out  8  output byte; stable while tx_valid=1 && tx_ready=0
//  tx_ready   in   1  UART accepts tx_data when tx_valid && tx_ready
//  fifo_level out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
//  drop_cnt   out  8  drops not yet reported; saturates at 255
// BEHAVIOUR
//  Reset (rst=0, async): tx_valid=0, tx_data=0, fifo_level=0, drop_cnt=0, state=IDLE,
//   FIFO empty, flags cleared, heartbeat timer=0. Outputs registered.
//  FIFO: 9-bit entries {pre_drop, byte}; pointers carry an extra wrap bit; full/empty from
//   pointer compare. Fullness sampled from registered state at the start of the cycle.
//  Write: ev_valid && !full -> push {drop_flag, ev_data}, drop_flag<=0.
//   ev_valid && full -> byte discarded, drop_cnt<=sat(drop_cnt+1), drop_flag<=1,
//   even if a pop occurs in the same cycle (no write-through at full).
//  Output stage is a single register; "slot free" = !tx_valid || tx_ready.
//  FSM: IDLE -> (slot free, FIFO non-empty): pop head; pre_drop=0 -> load byte, DATA;
//   pre_drop=1 -> load OVF_MARK, hold popped byte in a pend register, MARK.
//   DATA: on handshake, pop/load next entry in the same cycle (back-to-back, 1 byte/clk);
//   else IDLE with tx_valid=0.
//   MARK: on handshake load drop_cnt value -> CNT; drop_cnt<=0 (<=1 if a drop coincides).
//   CNT: on handshake load pend byte -> DATA.
//  Latency: ev_valid to tx_valid = 2 clks when FIFO empty and slot free.
//  Each marker pair reports all drops since the previous report (may span episodes).
//  fifo_level: +1 on push, -1 on pop, unchanged on both.
//  tx_data/tx_valid never change while tx_valid=1 && tx_ready=0.
//  Reset mid-transfer: in-flight byte and FIFO contents abandoned; no partial marker pair.
// CONFIGURATION
//  HEARTBEAT_EN defined: free-running timer counts 0..HB_PERIOD-1; at wrap sets hb_pend.
//   In IDLE with slot free, FIFO empty and no pend byte, hb_pend loads HB_BYTE (state HB)
//   and clears; FIFO data always wins. Timer runs through all states; one pending max.
//  HEARTBEAT_EN undefined: no timer or HB state; tx never carries HB_BYTE; HB_* ignored.
// TESTING
//  Reset: assert rst=0 mid-stream -> tx_valid=0, fifo_level=0, drop_cnt=0 immediately.
//  Pass-through, tx_ready=1: bytes 0x53,0x56,0x41,0x80 one per clk -> same 4 bytes in order,
//   tx_valid 2 clks after first ev_valid, fifo_level <= 2.
//  Backpressure: tx_ready=0 for 40 clks during 5-byte burst -> tx_data held stable, no loss,
//   fifo_level=4 (one in output reg), all 5 bytes emitted in order after release.
//  Overflow, DEPTH=16, tx_ready=0: push 20 bytes 0x00..0x13, then 0xAA, release ->
//   0x00..0x10 (17 incl. output reg), 0x4F, 0x03, 0xAA; drop_cnt peaks at 3, then 0.
//  Saturation: 300 drops while stalled -> count byte 0xFF.
//  HEARTBEAT_EN, HB_PERIOD=100: idle 350 clks -> 3 0x48 bytes; heartbeat during FIFO burst
//   is deferred until FIFO empty and never interleaves a 0x4F/count pair.

Source files
------------

// File: rtl/i2c_mon_tx_scheduler.sv
// Buffers i2c_monitor event bytes in a FIFO and schedules them onto a valid/ready TX port,
// reporting overflow drops in-band as {OVF_MARK, count}. Define HEARTBEAT_EN to add a heartbeat byte.
module i2c_mon_tx_scheduler #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] OVF_MARK  = 8'h4F,
    parameter logic [7:0] HB_BYTE   = 8'h48,
    parameter int         HB_PERIOD = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ev_valid,
    input  logic [7:0]             ev_data,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_cnt
);
    localparam int AW = $clog2(DEPTH);

`ifdef HEARTBEAT_EN
    typedef enum logic [2:0] {IDLE, DATA, MARK, CNT, HB} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, MARK, CNT} state_t;
`endif

    state_t      state;
    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        drop_flag;
    logic [7:0]  pend_byte;

    logic        full;
    logic        empty;
    logic        push;
    logic        drop;
    logic        hs;
    logic        pop;
    logic [8:0]  head;
    logic [7:0]  head_data;
    state_t      head_state;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Fullness comes from the registered pointers, so a same-cycle pop never rescues a byte at full.
    assign push  = ev_valid && !full;
    assign drop  = ev_valid && full;
    assign hs    = tx_valid && tx_ready;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_data  = head[8] ? OVF_MARK : head[7:0];
    assign head_state = head[8] ? MARK : DATA;

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            DATA:    pop = hs && !empty;
`ifdef HEARTBEAT_EN
            HB:      pop = hs && !empty;
`endif
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {drop_flag, ev_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_flag  <= 1'b0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                drop_flag <= 1'b0;
            end
            if (drop) begin
                drop_flag <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // The count byte is captured at the marker handshake; a drop in that same cycle starts the next report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 8'd0;
        end else if (state == MARK && hs) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef HEARTBEAT_EN
    localparam int TW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

    logic [TW-1:0] hb_timer;
    logic          hb_pend;
    logic          hb_take;

    assign hb_take = (state == IDLE) && empty && hb_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_timer <= '0;
            hb_pend  <= 1'b0;
        end else if (hb_timer == TW'(HB_PERIOD - 1)) begin
            hb_timer <= '0;
            hb_pend  <= 1'b1;
        end else begin
            hb_timer <= hb_timer + 1'b1;
            if (hb_take) begin
                hb_pend <= 1'b0;
            end
        end
    end
`else
    logic unused_hb;
    assign unused_hb = ^{HB_BYTE, HB_PERIOD};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'd0;
            pend_byte <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_valid  <= 1'b1;
                        tx_data   <= head_data;
                        pend_byte <= head[7:0];
                        state     <= head_state;
                    end
`ifdef HEARTBEAT_EN
                    else if (hb_pend) begin
                        tx_valid <= 1'b1;
                        tx_data  <= HB_BYTE;
                        state    <= HB;
                    end
`endif
                end
                MARK: begin
                    if (hs) begin
                        tx_data <= drop_cnt;
                        state   <= CNT;
                    end
                end
                CNT: begin
                    if (hs) begin
                        tx_data <= pend_byte;
                        state   <= DATA;
                    end
                end
                default: begin
                    // DATA (and HB): refill back-to-back on handshake, otherwise go idle.
                    if (pop) begin
                        tx_valid  <= 1'b1;
                        tx_data   <= head_data;
                        pend_byte <= head[7:0];
                        state     <= head_state;
                    end else if (hs) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_mon_tx_scheduler.sv
// Bench for i2c_mon_tx_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_i2c_mon_tx_scheduler;
    localparam int         DEPTH     = 16;
    localparam int         HB_PERIOD = 100;
    localparam logic [7:0] OVF       = 8'h4F;
    localparam logic [7:0] HBB       = 8'h48;

    logic       clk = 1'b0;
    logic       rst;
    logic       ev_valid;
    logic [7:0] ev_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [4:0] fifo_level;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    i2c_mon_tx_scheduler #(
        .DEPTH(DEPTH), .OVF_MARK(OVF), .HB_BYTE(HBB), .HB_PERIOD(HB_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_data(ev_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_hb  = 0;
    int cyc   = 0;
    bit verbose = 1'b0;
    logic [7:0] out_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: FIFO as a queue of {pre_drop, byte}; a flagged entry expands into an emission
    // queue {marker, deferred count entry (-1), byte}; the count is resolved when it is emitted.
    logic [8:0] mq[$];
    int         m_emit[$];
    logic       m_valid;
    logic [7:0] m_data;
    int         m_drops;
    logic       m_flag;
    int         m_timer;
    logic       m_hb;

    function automatic void model_reset();
        mq.delete();
        m_emit.delete();
        m_valid = 1'b0;
        m_data  = 8'd0;
        m_drops = 0;
        m_flag  = 1'b0;
        m_timer = 0;
        m_hb    = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d, input logic r);
        bit         full_now;
        bit         was_valid;
        bit         free;
        bit         drp;
        bit         count_taken;
        int         cnt_snap;
        int         e;
        logic [8:0] h;
        full_now    = (mq.size() == DEPTH);
        was_valid   = m_valid;
        free        = !m_valid || r;
        drp         = v && full_now;
        count_taken = 1'b0;
        cnt_snap    = m_drops;
        if (free) begin
            if (m_emit.size() != 0) begin
                e = m_emit.pop_front();
                m_valid = 1'b1;
                if (e < 0) begin
                    m_data = 8'(cnt_snap);
                    count_taken = 1'b1;
                end else begin
                    m_data = 8'(e);
                end
            end else if (mq.size() != 0) begin
                h = mq.pop_front();
                m_valid = 1'b1;
                if (h[8]) begin
                    m_data = OVF;
                    m_emit.push_back(-1);
                    m_emit.push_back(int'(h[7:0]));
                end else begin
                    m_data = h[7:0];
                end
            end
`ifdef HEARTBEAT_EN
            else if (!was_valid && m_hb) begin
                m_valid = 1'b1;
                m_data  = HBB;
                m_hb    = 1'b0;
            end
`endif
            else begin
                m_valid = 1'b0;
            end
        end
        if (v && !full_now) begin
            mq.push_back({m_flag, d});
            m_flag = 1'b0;
        end
        if (drp) m_flag = 1'b1;
        if (count_taken) m_drops = drp ? 1 : 0;
        else if (drp && m_drops < 255) m_drops = m_drops + 1;
`ifdef HEARTBEAT_EN
        if (m_timer == HB_PERIOD - 1) begin
            m_timer = 0;
            m_hb    = 1'b1;
        end else begin
            m_timer = m_timer + 1;
        end
`endif
    endfunction

    task automatic log_byte(input logic [7:0] b);
`ifdef HEARTBEAT_EN
        if (b == HBB) begin
            n_hb++;
            return;
        end
`endif
        out_log.push_back(b);
        if (verbose) $display("tx byte %02h at cycle %0d", b, cyc);
    endtask

    // Called at posedge+1: drive inputs, advance model, sample DUT at next posedge+1.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        ev_valid = v;
        ev_data  = d;
        tx_ready = r;
        if (tx_valid && tx_ready) log_byte(tx_data);
        model_step(v, d, r);
        @(posedge clk);
        #1;
        cyc++;
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
        if (m_valid) check("tx_data", {24'd0, tx_data}, {24'd0, m_data});
        check("fifo_level", {27'd0, fifo_level}, mq.size());
        check("drop_cnt", {24'd0, drop_cnt}, m_drops);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_fifo_level", {27'd0, fifo_level}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        model_reset();
        ev_valid = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp_q[$]);
        check({tag, "_len"}, out_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
            check($sformatf("%s[%0d]", tag, i), {24'd0, out_log[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] pt_bytes[4];
        model_reset();
        rst = 1'b0;
        ev_valid = 1'b0;
        ev_data = 8'd0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("init_tx_data", {24'd0, tx_data}, 32'd0);
        check("init_fifo_level", {27'd0, fifo_level}, 32'd0);
        check("init_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b1;
        verbose = 1'b1;

        // Pass-through at full rate.
        out_log.delete();
        pt_bytes = '{8'h53, 8'h56, 8'h41, 8'h80};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pt_bytes[i], 1'b1);
            if (i == 0) check("pt_lat1", {31'd0, tx_valid}, 32'd0);
            if (i == 1) check("pt_lat2", {31'd0, tx_valid}, 32'd1);
            check("pt_lvl_le2", {31'd0, fifo_level <= 5'd2}, 32'd1);
        end
        drain(6);
        exp_q = '{8'h53, 8'h56, 8'h41, 8'h80};
        check_log("pt_log", exp_q);

        // Backpressure: 40 stalled clocks around a 5-byte burst.
        do_reset();
        out_log.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 8'h61 + 8'(i), 1'b0);
        for (int i = 0; i < 35; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("bp_hold", {24'd0, tx_data}, 32'h61);
        end
        check("bp_level", {27'd0, fifo_level}, 32'd4);
        drain(10);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        check_log("bp_log", exp_q);

        // Overflow: 20 bytes into a stalled 16-deep FIFO, then release and send 0xAA.
        do_reset();
        out_log.delete();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0);
        check("ovf_peak", {24'd0, drop_cnt}, 32'd3);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hAA, 1'b1);
        drain(30);
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(OVF);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hAA);
        check_log("ovf_log", exp_q);
        check("ovf_cleared", {24'd0, drop_cnt}, 32'd0);

        // Saturation: 303 drops reported as 0xFF.
        do_reset();
        out_log.delete();
        for (int i = 0; i < 320; i++) step(1'b1, 8'h20 + 8'(i % 16), 1'b0);
        check("sat_cnt", {24'd0, drop_cnt}, 32'hFF);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        drain(60);
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'h20 + 8'(i % 16));
        exp_q.push_back(OVF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h77);
        check_log("sat_log", exp_q);
        check("sat_cleared", {24'd0, drop_cnt}, 32'd0);

`ifdef HEARTBEAT_EN
        do_reset();
        n_hb = 0;
        for (int i = 0; i < 350; i++) step(1'b0, 8'h00, 1'b1);
        check("hb_idle_cnt", n_hb, 32'd3);
`endif

        // Randomized traffic with varying load/stall mixes and a mid-stream reset.
        verbose = 1'b0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int   mode;
            int   pv;
            int   pr;
            logic v;
            logic r;
            mode = (i / 500) % 4;
            pv = (mode == 0) ? 30 : (mode == 1) ? 90 : (mode == 2) ? 60 : 100;
            pr = (mode == 1) ? 20 : (mode == 3) ? 5 : 70;
            v = ($urandom_range(0, 99) < pv);
            r = ($urandom_range(0, 99) < pr);
            step(v, 8'($urandom), r);
            if (i == 1777) do_reset();
        end
        drain(100);
        check("end_level", {27'd0, fifo_level}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
